load_store_unit: RTL and testbench

Memory-access controller between the MIPS datapath and the word-organised `DataMemory` (1024 × 32, synchronous read and write, 10-bit word address). It accepts byte, halfword and word load/store requests at 32-bit byte addresses and converts each one into `DataMemory` read/write cycles. Loads get lane extraction with sign or zero extension. Sub-word stores are done as read-modify-write, because the memory has no byte enables.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Sits between the datapath and a word-organised synchronous DataMemory.
// It turns byte, halfword and word loads/stores at byte addresses into
// DataMemory read and write cycles. Loads get lane extraction with sign or
// zero extension. Sub-word stores are done as read-modify-write because the
// memory has no byte enables.
//
// Ports:
//   clk, reset         clock (rising edge); asynchronous active-low reset
//   req, we, size,     request handshake and attributes; sampled in IDLE only
//   sign_ext, addr,
//   wdata
//   rdata              load result, held until the next load completes
//   done, misalign     one-cycle completion pulse / misaligned-request flag
//   busy               high in every state except IDLE
//   mem_addr, mem_din, DataMemory command side
//   mem_wen, mem_ren
//   mem_dout           DataMemory read data (valid the cycle after mem_ren)
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        we_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic [1:0]  off_r;
    logic [15:0] wdata_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        unused_addr_s;

    // Halfwords need an even address. Words, and the reserved size code
    // (which behaves as a word), need a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    // Select the addressed little-endian lane of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sext);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        case (sz)
            2'b00:   res = {{24{sext & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s) of the old word with the low bits
    // of the store data. The other lanes pass through unchanged.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [15:0] new_data,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        case (sz)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {4{new_data[7:0]}};
            end
            2'b01: begin
                mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                data = {2{new_data}};
            end
            default: begin
                mask = 32'h0000_0000;
                data = 32'h0000_0000;
            end
        endcase
        return (old_word & ~mask) | (data & mask);
    endfunction

    // Byte-address bits above the word index wrap around and are not used.
    assign unused_addr_s = ^addr[31:ADDR_W+2];
    assign accept_s      = (state_r == ST_IDLE) && req;
    assign misaligned_s  = is_misaligned(size, addr[1:0]);

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned_s) begin
                        state_nxt_s = ST_ERR;
                    end else if (we && size[1]) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    state_nxt_s = ST_MERGE;
                end else begin
                    state_nxt_s = ST_CAP;
                end
            end
            ST_CAP:   state_nxt_s = ST_DONE;
            ST_MERGE: state_nxt_s = ST_WR;
            ST_WR:    state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ERR:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the request attributes at acceptance so later input changes
    // cannot affect an operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            sext_r  <= 1'b0;
            off_r   <= 2'b00;
            wdata_r <= 16'h0000;
        end else if (accept_s) begin
            we_r    <= we;
            size_r  <= size;
            sext_r  <= sign_ext;
            off_r   <= addr[1:0];
            wdata_r <= wdata[15:0];
        end
    end

    // Registered outputs. The strobes are decoded from the next state so
    // they line up exactly with the cycles spent in RD, WR, DONE and ERR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata    <= 32'h0000_0000;
            done     <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 32'h0000_0000;
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
        end else begin
            done     <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_ERR);
            misalign <= (state_nxt_s == ST_ERR);
            busy     <= (state_nxt_s != ST_IDLE);
            mem_ren  <= (state_nxt_s == ST_RD);
            mem_wen  <= (state_nxt_s == ST_WR);
            if (accept_s) begin
                mem_addr <= addr[ADDR_W+1:2];
                // A word store goes straight to WR, so its data is loaded here.
                mem_din  <= wdata;
            end else if (state_r == ST_MERGE) begin
                mem_din  <= store_merge(mem_dout, wdata_r, size_r, off_r);
            end
            if (state_r == ST_CAP) begin
                rdata <= load_extract(mem_dout, size_r, off_r, sext_r);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        misalign;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int wen_cnt = 0;
    int exp_ren = 0;
    int exp_wen = 0;
    logic [31:0] last_rd;

    typedef struct packed {
        logic [31:0] cyc;
        logic        mis;
        logic [31:0] rd;
    } done_exp_t;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_exp_t;

    done_exp_t dq[$];
    wr_exp_t   wq[$];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .busy(busy), .misalign(misalign), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_dout(mem_dout)
    );

    // Behavioural DataMemory: synchronous read and write.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares writes and completions against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_ren) ren_cnt++;
            if (mem_wen) wen_cnt++;
            if (mem_ren && mem_wen) check32("ren_wen_exclusive", 32'd1, 32'd0);
            if (mem_wen) begin
                if (wq.size() == 0) begin
                    check32("unexpected_write", {22'd0, mem_addr}, 32'd0);
                end else begin
                    wr_exp_t w;
                    w = wq.pop_front();
                    check32("wr_addr", {22'd0, mem_addr}, {22'd0, w.a});
                    check32("wr_data", mem_din, w.d);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check32("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_exp_t e;
                    e = dq.pop_front();
                    check32("done_cycle", cyc, e.cyc);
                    check32("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    check32("rdata", rdata, e.rd);
                end
            end
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) check32("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one request and push its expected responses into the scoreboard.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic mis, input logic [31:0] erd, input logic [31:0] edin);
        done_exp_t e;
        wr_exp_t   x;
        wait_idle();
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        // Scramble inputs: the operation must rely on its latched copy.
        we = ~w; size = ~sz; sign_ext = ~sx; addr = 32'hFFFF_FFFF; wdata = 32'hDEAD_BEEF;
        if (!mis && !w) last_rd = erd;
        e.cyc = cyc + lat - 1;
        e.mis = mis;
        e.rd  = last_rd;
        dq.push_back(e);
        if (!mis && w) begin
            x.a = a[11:2];
            x.d = edin;
            wq.push_back(x);
            exp_wen++;
        end
        if (!mis && !(w && sz[1])) exp_ren++;
    endtask

    initial begin
        done_exp_t e;
        wr_exp_t   x;
        int c0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_dout = 32'h0;
        req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #11;
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_ctrl", {28'd0, done, busy, misalign, mem_wen}, 32'h0);
        check32("rst_mem", {21'd0, mem_ren, mem_addr}, 32'h0);
        check32("rst_din", mem_din, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // w, size, sext, addr, wdata, latency, misaligned, expected rdata, expected din
        do_req(1'b1, 2'b10, 1'b0, 32'h3C, 32'hCAFEBABE, 2, 1'b0, 32'h0,        32'hCAFEBABE);
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        3, 1'b0, 32'hCAFEBABE, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h3D, 32'h0,        3, 1'b0, 32'hFFFFFFBA, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h3D, 32'h0,        3, 1'b0, 32'h000000BA, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h3E, 32'h0,        3, 1'b0, 32'hFFFFCAFE, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h3C, 32'h0,        3, 1'b0, 32'hFFFFBABE, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h3E, 32'h0,        3, 1'b0, 32'h0000CAFE, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h3C, 32'h0,        3, 1'b0, 32'hFFFFFFBE, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h3F, 32'h0,        3, 1'b0, 32'h000000CA, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h3F, 32'hAABBCC11, 4, 1'b0, 32'h0,        32'h11FEBABE);
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        3, 1'b0, 32'h11FEBABE, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h3D, 32'h12345555, 1, 1'b1, 32'h0,        32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h3E, 32'h0,        1, 1'b1, 32'h0,        32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h3E, 32'h12347777, 4, 1'b0, 32'h0,        32'h7777BABE);
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        3, 1'b0, 32'h7777BABE, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        3, 1'b0, 32'h00000000, 32'h0);

        // req held high through a word store at an aliased address.
        wait_idle();
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h1000_003C; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        e.cyc = c0 + 1; e.mis = 1'b0; e.rd = last_rd;
        dq.push_back(e);
        x.a = 10'd15; x.d = 32'h12345678;
        wq.push_back(x);
        exp_wen++;
        we = 1'b0; addr = 32'h3C;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        check32("held_req_busy", {31'd0, busy}, 32'd1);
        exp_ren++;
        last_rd = 32'h12345678;
        e.cyc = c0 + 5; e.mis = 1'b0; e.rd = last_rd;
        dq.push_back(e);

        // Reset asserted during the MERGE cycle of a byte store.
        wait_idle();
        we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h3C; wdata = 32'h55; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        exp_ren++;
        @(posedge clk);
        #1;
        check32("merge_busy", {30'd0, busy, mem_ren}, 32'd2);
        #1 reset = 1'b0;
        #1;
        check32("abort_rdata", rdata, 32'h0);
        check32("abort_ctrl", {28'd0, done, busy, misalign, mem_wen}, 32'h0);
        check32("abort_mem", {21'd0, mem_ren, mem_addr}, 32'h0);
        check32("abort_din", mem_din, 32'h0);
        @(posedge clk);
        #1;
        check32("abort_no_wen", {31'd0, mem_wen}, 32'd0);
        check32("abort_mem15", mem[15], 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        last_rd = 32'h0;

        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 3, 1'b0, 32'h12345678, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h01, 32'h0, 1, 1'b1, 32'h0,        32'h0);

        for (int i = 0; i < 100 && (dq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check32("queue_drain", dq.size() + wq.size(), 32'd0);
        check32("ren_count", ren_cnt, exp_ren);
        check32("wen_count", wen_cnt, exp_wen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
